source_ctrl: RTL and testbench

Frame sequencer for the SOURCE excitation generator. Accepts speech frames (pitch period, amplitude, duration) over a valid/ready handshake and generates the sample strobe. It drives SOURCE's period/amplitude inputs, applying pitch changes only on pitch-period boundaries and ramping amplitude exponentially to avoid clicks. It sits between the allophone/frame decoder and SOURCE.

---
 rtl/source_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_source_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/source_ctrl.sv
// Frame sequencer for the SOURCE excitation generator: frame handshake, sample
// strobe, pitch changes aligned to period boundaries, exponential amplitude ramp.
module source_ctrl #(
  parameter int unsigned CLK_DIV          = 5,
  parameter int unsigned SAMPLES_PER_UNIT = 16,
  parameter int unsigned AMP_SHIFT        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [7:0]  frame_period,
  input  logic [14:0] frame_amp,
  input  logic [7:0]  frame_len,
  output logic [7:0]  src_period,
  output logic [14:0] src_amp,
  output logic        src_strobe,
  input  logic        src_period_done,
  output logic        busy,
  output logic        underrun
);

  localparam int unsigned      CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam int unsigned      SPU_SHIFT = $clog2(SAMPLES_PER_UNIT);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // A zero-length frame still plays for one unit.
  function automatic logic [15:0] frame_samples(input logic [7:0] len);
    logic [15:0] units;
    units = (len == 8'd0) ? 16'd1 : {8'd0, len};
    return units << SPU_SHIFT;
  endfunction

  state_e             state_q,          state_d;
  logic [CNT_W-1:0]   count_q,          count_d;
  logic               shadow_valid_q,   shadow_valid_d;
  logic [7:0]         shadow_period_q,  shadow_period_d;
  logic [14:0]        shadow_amp_q,     shadow_amp_d;
  logic [7:0]         shadow_len_q,     shadow_len_d;
  logic               frame_ready_q,    frame_ready_d;
  logic [15:0]        remaining_q,      remaining_d;
  logic [14:0]        target_amp_q,     target_amp_d;
  logic [7:0]         pending_period_q, pending_period_d;
  logic               idle_xfer_q,      idle_xfer_d;
  logic [7:0]         src_period_q,     src_period_d;
  logic [14:0]        src_amp_q,        src_amp_d;
  logic               underrun_q,       underrun_d;

  logic               strobe;
  logic               handshake;
  logic               load_shadow;
  logic               load_direct;
  logic signed [15:0] amp_diff;
  logic signed [15:0] amp_step;

  assign strobe    = (count_q == CNT_LAST);
  assign handshake = frame_valid & frame_ready_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    count_d          = strobe ? '0 : count_q + 1'b1;
    state_d          = state_q;
    shadow_valid_d   = shadow_valid_q;
    shadow_period_d  = shadow_period_q;
    shadow_amp_d     = shadow_amp_q;
    shadow_len_d     = shadow_len_q;
    remaining_d      = remaining_q;
    target_amp_d     = target_amp_q;
    pending_period_d = pending_period_q;
    idle_xfer_d      = 1'b0;
    underrun_d       = 1'b0;
    load_shadow      = 1'b0;
    load_direct      = 1'b0;

    if (handshake) begin
      shadow_valid_d  = 1'b1;
      shadow_period_d = frame_period;
      shadow_amp_d    = frame_amp;
      shadow_len_d    = frame_len;
    end

    unique case (state_q)
      IDLE: begin
        if (shadow_valid_q) begin
          load_shadow = 1'b1;
          idle_xfer_d = 1'b1;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (strobe) begin
          if (remaining_q == 16'd1) begin
            if (shadow_valid_q) begin
              load_shadow = 1'b1;
            end else if (handshake) begin
              load_direct = 1'b1;
            end else begin
              underrun_d   = 1'b1;
              target_amp_d = '0;
              state_d      = IDLE;
            end
          end else begin
            remaining_d = remaining_q - 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_shadow) begin
      target_amp_d     = shadow_amp_q;
      pending_period_d = shadow_period_q;
      remaining_d      = frame_samples(shadow_len_q);
      shadow_valid_d   = 1'b0;
    end

    // Frame arriving exactly at frame end bypasses the shadow register.
    if (load_direct) begin
      target_amp_d     = frame_amp;
      pending_period_d = frame_period;
      remaining_d      = frame_samples(frame_len);
      shadow_valid_d   = 1'b0;
    end

    frame_ready_d = ~shadow_valid_d;

    // Pitch only moves on a boundary, during noise, or right after starting from idle.
    src_period_d = src_period_q;
    if ((pending_period_q != src_period_q) &&
        (src_period_done || (src_period_q == 8'd0) || idle_xfer_q)) begin
      src_period_d = pending_period_q;
    end

    amp_diff  = $signed({target_amp_q[14], target_amp_q}) - $signed({src_amp_q[14], src_amp_q});
    amp_step  = amp_diff >>> AMP_SHIFT;
    src_amp_d = src_amp_q;
    if (strobe) begin
      src_amp_d = (amp_step == 16'sd0) ? target_amp_q : src_amp_q + amp_step[14:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q          <= IDLE;
      count_q          <= '0;
      shadow_valid_q   <= 1'b0;
      shadow_period_q  <= '0;
      shadow_amp_q     <= '0;
      shadow_len_q     <= '0;
      frame_ready_q    <= 1'b0;
      remaining_q      <= '0;
      target_amp_q     <= '0;
      pending_period_q <= '0;
      idle_xfer_q      <= 1'b0;
      src_period_q     <= '0;
      src_amp_q        <= '0;
      underrun_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      shadow_valid_q   <= shadow_valid_d;
      shadow_period_q  <= shadow_period_d;
      shadow_amp_q     <= shadow_amp_d;
      shadow_len_q     <= shadow_len_d;
      frame_ready_q    <= frame_ready_d;
      remaining_q      <= remaining_d;
      target_amp_q     <= target_amp_d;
      pending_period_q <= pending_period_d;
      idle_xfer_q      <= idle_xfer_d;
      src_period_q     <= src_period_d;
      src_amp_q        <= src_amp_d;
      underrun_q       <= underrun_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign src_period  = src_period_q;
  assign src_amp     = src_amp_q;
  assign src_strobe  = strobe;
  assign busy        = (state_q == PLAY);
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_source_ctrl.sv
// Directed bench for source_ctrl: strobe timing, single frame with ramp and
// underrun, back-to-back frames, noise switching, backpressure, mid-frame reset.
module tb_source_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  frame_period;
  logic [14:0] frame_amp;
  logic [7:0]  frame_len;
  logic [7:0]  src_period;
  logic [14:0] src_amp;
  logic        src_strobe;
  logic        src_period_done;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  source_ctrl #(
    .CLK_DIV          (5),
    .SAMPLES_PER_UNIT (16),
    .AMP_SHIFT        (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .frame_period    (frame_period),
    .frame_amp       (frame_amp),
    .frame_len       (frame_len),
    .src_period      (src_period),
    .src_amp         (src_amp),
    .src_strobe      (src_strobe),
    .src_period_done (src_period_done),
    .busy            (busy),
    .underrun        (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // NOTE: inputs change and outputs are sampled 1 time unit after the rising
  // edge, so the DUT never sees a race against its own clock.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] p,
                            input logic [14:0] a, input logic [7:0] l);
    int n;
    n = 0;
    frame_valid  = 1'b1;
    frame_period = p;
    frame_amp    = a;
    frame_len    = l;
    while (!frame_ready && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, frame_ready, 1);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int ur_cnt);
    int n;
    n      = 0;
    ur_cnt = 0;
    while (!frame_ready && n < 500) begin
      tick();
      n++;
      if (underrun) ur_cnt++;
    end
    check({tag, "_ready"}, frame_ready, 1);
  endtask

  task automatic wait_underrun(input string tag);
    int n;
    n = 0;
    while (!underrun && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_underrun"}, underrun, 1);
  endtask

  initial begin
    int          n_strobe;
    int          ur_cnt;
    int          bad;
    logic        seen_ur;
    logic [14:0] amp_before;

    rst             = 1'b1;
    frame_valid     = 1'b0;
    frame_period    = '0;
    frame_amp       = '0;
    frame_len       = '0;
    src_period_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and strobe timing: strobes on clocks 5, 10, 15, 20.
    check("rst_src_amp",    src_amp,    0);
    check("rst_src_period", src_period, 0);
    check("rst_busy",       busy,       0);
    check("rst_underrun",   underrun,   0);
    check("rst_ready",      frame_ready, 0);
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      if (src_strobe !== ((k % 5) == 0)) bad++;
      tick();
    end
    check("strobe_pattern_errs", bad, 0);
    check("idle_ready",  frame_ready, 1);
    check("idle_amp",    src_amp,     0);
    check("idle_period", src_period,  0);
    check("idle_busy",   busy,        0);

    // Single frame, no successor.
    send_frame("f1", 8'd50, 15'd15000, 8'd2);
    check("f1_busy_before_xfer", busy, 0);
    check("f1_ready_full", frame_ready, 0);
    tick();
    check("f1_busy_after_xfer", busy, 1);
    tick();
    check("f1_period", src_period, 50);
    n_strobe = 0;
    seen_ur  = 1'b0;
    for (int i = 0; i < 400 && !seen_ur; i++) begin
      if (src_strobe) begin
        n_strobe++;
        tick();
        if (n_strobe == 1) check("f1_ramp1", src_amp, 1875);
        if (n_strobe == 2) check("f1_ramp2", src_amp, 3515);
      end else begin
        tick();
      end
      if (underrun) seen_ur = 1'b1;
    end
    check("f1_underrun_seen", seen_ur, 1);
    check("f1_strobe_count", n_strobe, 32);
    check("f1_busy_at_underrun", busy, 0);
    amp_before = src_amp;
    tick();
    check("f1_underrun_single", underrun, 0);
    for (int i = 0; i < 10; i++) tick();
    check("f1_decay", (src_amp < amp_before), 1);
    check("f1_period_held", src_period, 50);

    // Back-to-back frames: period 50 then 80.
    send_frame("b2b_a", 8'd50, 15'd8000, 8'd1);
    send_frame("b2b_b", 8'd80, 15'd8000, 8'd1);
    wait_ready("b2b", ur_cnt);
    check("b2b_no_underrun", ur_cnt, 0);
    check("b2b_busy", busy, 1);
    check("b2b_period_hold0", src_period, 50);
    tick();
    tick();
    tick();
    check("b2b_period_hold1", src_period, 50);
    src_period_done = 1'b1;
    check("b2b_period_pre_done", src_period, 50);
    tick();
    src_period_done = 1'b0;
    check("b2b_period_post_done", src_period, 80);

    // Noise frame waits for a boundary; leaving noise does not.
    send_frame("noise", 8'd0, 15'd4000, 8'd1);
    wait_ready("noise", ur_cnt);
    check("noise_no_underrun", ur_cnt, 0);
    check("noise_hold0", src_period, 80);
    tick();
    tick();
    tick();
    check("noise_hold1", src_period, 80);
    src_period_done = 1'b1;
    tick();
    src_period_done = 1'b0;
    check("noise_entered", src_period, 0);
    send_frame("tone", 8'd60, 15'd4000, 8'd1);
    wait_ready("tone", ur_cnt);
    check("tone_no_underrun", ur_cnt, 0);
    check("tone_at_xfer", src_period, 0);
    tick();
    check("tone_next_cycle", src_period, 60);

    // Backpressure: shadow full while a frame plays.
    send_frame("bp_e", 8'd60, 15'd4000, 8'd2);
    frame_valid  = 1'b1;
    frame_period = 8'd60;
    frame_amp    = 15'd1000;
    frame_len    = 8'd1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_ready !== 1'b0) bad++;
      tick();
    end
    check("bp_ready_low_errs", bad, 0);
    wait_ready("bp_release", ur_cnt);
    check("bp_no_underrun0", ur_cnt, 0);
    tick();
    frame_valid = 1'b0;
    check("bp_accepted_once", frame_ready, 0);
    wait_ready("bp_f_xfer", ur_cnt);
    check("bp_no_underrun1", ur_cnt, 0);
    wait_underrun("bp_f_end");
    check("bp_f_end_busy", busy, 0);

    // Reset mid-frame with shadow full.
    send_frame("rst_g", 8'd50, 15'd5000, 8'd1);
    send_frame("rst_h", 8'd70, 15'd6000, 8'd1);
    n_strobe = 0;
    for (int i = 0; i < 200 && n_strobe < 4; i++) begin
      if (src_strobe) n_strobe++;
      tick();
    end
    check("mid_strobes", n_strobe, 4);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_amp",    src_amp,     0);
    check("mid_rst_period", src_period,  0);
    check("mid_rst_strobe", src_strobe,  0);
    check("mid_rst_busy",   busy,        0);
    check("mid_rst_under",  underrun,    0);
    check("mid_rst_ready",  frame_ready, 0);
    rst = 1'b0;
    tick();
    check("mid_rel_ready", frame_ready, 1);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (busy !== 1'b0 || underrun !== 1'b0) bad++;
      tick();
    end
    check("mid_shadow_lost_errs", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
